// File: rtl/fm_sb_pkg.sv
// Shared types and constants for the FM spy buffer with playback.
// Holds playback mode codes, the control state enum, the metadata record
// and a parameter bundle for instantiating blocks.
package fm_sb_pkg;

    localparam logic [1:0] PB_SPY  = 2'd0;
    localparam logic [1:0] PB_ONCE = 2'd1;
    localparam logic [1:0] PB_LOOP = 2'd2;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_POST    = 2'd1,
        ST_FROZEN  = 2'd2,
        ST_PLAY    = 2'd3
    } sb_state_t;

    // Trigger record: wrapped flag and write pointer at the moment of the trigger
    typedef struct packed {
        logic        wrapped;
        logic [15:0] wr_ptr;
    } sb_meta_t;

    typedef struct packed {
        int unsigned data_width;
        int unsigned axi_dw;
        int unsigned mem_depth;
        int unsigned meta_depth;
        int unsigned pb_mode_width;
    } fm_sb_cfg_t;

    localparam fm_sb_cfg_t FM_SB_CFG_DEFAULT = '{256, 32, 1024, 32, 2};

    // Flatten a metadata record as {pad, wrapped, wr_ptr[aw-1:0]}
    function automatic logic [31:0] sb_meta_pack(input sb_meta_t m, input int unsigned aw);
        logic [31:0] w;
        w = 32'(m.wr_ptr) & ((32'd1 << aw) - 32'd1);
        w = w | (32'(m.wrapped) << aw);
        return w;
    endfunction

endpackage

// File: rtl/fm_sb_sdp_ram.sv
// Simple dual-port RAM: one write port with per-lane enables, one read port.
// Read latency 1 cycle (registered); read-during-write to the same address returns old data.
// No backpressure; a write and a read can be issued every cycle.
module fm_sb_sdp_ram #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 32,
    parameter  int NSL   = 1,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LW    = DW / NSL
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NSL-1:0] i_wr_be,
    input  logic [AW-1:0]  i_wr_addr,
    input  logic [DW-1:0]  i_wr_data,
    input  logic [AW-1:0]  i_rd_addr,
    output logic [DW-1:0]  o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_q;

    // Lane-granular write; storage itself is never reset
    always_ff @(posedge clk) begin
        for (int s = 0; s < NSL; s++) begin
            if (i_wr_be[s]) begin
                r_mem[i_wr_addr][s*LW +: LW] <= i_wr_data[s*LW +: LW];
            end
        end
    end

    // Registered read; sees the pre-write contents on an address collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_q;

endmodule

// File: rtl/fm_spybuffer_pb.sv
// Spy buffer: circular capture, trigger freeze with post-count, metadata log, AXI slice access, playback.
// Capture writes land on the clk edge; AXI reads and playback have 2-cycle latency.
// No backpressure: capture, AXI and playback streams are accepted/emitted every cycle.
module fm_spybuffer_pb
    import fm_sb_pkg::*;
#(
    parameter  int DATA_WIDTH    = 256,
    parameter  int AXI_DW        = 32,
    parameter  int MEM_DEPTH     = 1024,
    parameter  int META_DEPTH    = 32,
    parameter  int PB_MODE_WIDTH = 2,
    localparam int AW            = $clog2(MEM_DEPTH),
    localparam int MW            = $clog2(META_DEPTH),
    localparam int NSL           = DATA_WIDTH / AXI_DW,
    localparam int SW            = (NSL > 1) ? $clog2(NSL) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    spy_data_i,
    input  logic                     spy_vld_i,
    input  logic                     freeze_i,
    input  logic                     release_i,
    input  logic [AW-1:0]            post_trig_i,
    input  logic [PB_MODE_WIDTH-1:0] pb_mode_i,
    input  logic [AW:0]              pb_len_i,
    input  logic [AW+SW-1:0]         sb_addr_i,
    input  logic                     sb_en_i,
    input  logic                     sb_wr_en_i,
    input  logic [AXI_DW-1:0]        sb_wr_data_i,
    output logic [AXI_DW-1:0]        sb_rd_data_o,
    output logic                     sb_rd_vld_o,
    input  logic [MW-1:0]            sm_addr_i,
    input  logic                     sm_en_i,
    output logic [AXI_DW-1:0]        sm_rd_data_o,
    output logic                     sm_rd_vld_o,
    output logic [DATA_WIDTH-1:0]    pb_data_o,
    output logic                     pb_vld_o,
    output logic                     frozen_o,
    output logic                     wrapped_o,
    output logic [AW-1:0]            wr_ptr_o,
    output logic [MW:0]              meta_cnt_o
);

    // Control state
    sb_state_t   r_state;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_cnt;
    logic [MW-1:0] r_meta_wp;
    logic [MW:0]   r_meta_cnt;
    logic          r_wrapped;
    logic          r_frozen;
    logic          r_pb_done;

    // Read pipelines
    logic            r_sb_vld_d1;
    logic [SW-1:0]   r_sb_slice_d1;
    logic            r_sm_vld_d1;
    logic            r_pb_vld_d1;
    logic [AXI_DW-1:0]     r_sb_rd_data;
    logic                  r_sb_rd_vld;
    logic [AXI_DW-1:0]     r_sm_rd_data;
    logic                  r_sm_rd_vld;
    logic [DATA_WIDTH-1:0] r_pb_data;
    logic                  r_pb_vld;

    logic [AW-1:0]         w_sb_word;
    logic [SW-1:0]         w_sb_slice;
    logic                  w_mode_pb;
    logic                  w_mode_once;
    logic                  w_cap_wr;
    logic                  w_axi_wr;
    logic                  w_meta_wr;
    logic                  w_pb_issue;
    logic [AW:0]           w_eff_len;
    logic                  w_at_last;
    logic [NSL-1:0]        w_dat_be;
    logic [AW-1:0]         w_dat_waddr;
    logic [DATA_WIDTH-1:0] w_dat_wdata;
    logic [AW-1:0]         w_dat_raddr;
    logic [DATA_WIDTH-1:0] w_dat_q;
    logic [AXI_DW-1:0]     w_meta_q;
    logic [AXI_DW-1:0]     w_meta_wdata;
    logic [AXI_DW-1:0]     w_slice_q;
    sb_meta_t              w_meta_rec;

    assign w_sb_word   = sb_addr_i[AW+SW-1:SW];
    assign w_sb_slice  = sb_addr_i[SW-1:0];
    assign w_mode_once = (pb_mode_i == PB_MODE_WIDTH'(PB_ONCE));
    assign w_mode_pb   = w_mode_once || (pb_mode_i == PB_MODE_WIDTH'(PB_LOOP));
    assign w_cap_wr    = spy_vld_i && ((r_state == ST_CAPTURE) || (r_state == ST_POST));
    assign w_axi_wr    = sb_en_i && sb_wr_en_i && ((r_state == ST_FROZEN) || (r_state == ST_PLAY));
    assign w_meta_wr   = freeze_i && (r_state == ST_CAPTURE);
    // A playback read is issued every PLAY cycle unless this cycle aborts it
    assign w_pb_issue  = (r_state == ST_PLAY) && !release_i && w_mode_pb;
    // Zero and out-of-range lengths replay the whole memory
    assign w_eff_len   = ((pb_len_i == '0) || (pb_len_i > (AW+1)'(MEM_DEPTH))) ?
                         (AW+1)'(MEM_DEPTH) : pb_len_i;
    assign w_at_last   = (({1'b0, r_rd_ptr} + (AW+1)'(1)) == w_eff_len);
    // The single read port belongs to playback while in PLAY; AXI reads then see the replayed word
    assign w_dat_raddr = (r_state == ST_PLAY) ? r_rd_ptr : w_sb_word;

    // Data write port: full-word capture or a single-slice AXI update
    always_comb begin
        w_dat_be    = '0;
        w_dat_waddr = w_sb_word;
        w_dat_wdata = {NSL{sb_wr_data_i}};
        if (w_cap_wr) begin
            w_dat_be    = '1;
            w_dat_waddr = r_wr_ptr;
            w_dat_wdata = spy_data_i;
        end else if (w_axi_wr) begin
            for (int s = 0; s < NSL; s++) begin
                if (w_sb_slice == SW'(s)) begin
                    w_dat_be[s] = 1'b1;
                end
            end
        end
    end

    // Metadata entry captured at the trigger
    always_comb begin
        w_meta_rec.wrapped = r_wrapped;
        w_meta_rec.wr_ptr  = 16'(r_wr_ptr);
        w_meta_wdata       = AXI_DW'(sb_meta_pack(w_meta_rec, AW));
    end

    // AXI slice select on the registered RAM word
    always_comb begin
        w_slice_q = w_dat_q[AXI_DW-1:0];
        for (int s = 0; s < NSL; s++) begin
            if (r_sb_slice_d1 == SW'(s)) begin
                w_slice_q = w_dat_q[s*AXI_DW +: AXI_DW];
            end
        end
    end

    fm_sb_sdp_ram #(.DW(DATA_WIDTH), .DEPTH(MEM_DEPTH), .NSL(NSL)) u_dat_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_be   (w_dat_be),
        .i_wr_addr (w_dat_waddr),
        .i_wr_data (w_dat_wdata),
        .i_rd_addr (w_dat_raddr),
        .o_rd_data (w_dat_q)
    );

    fm_sb_sdp_ram #(.DW(AXI_DW), .DEPTH(META_DEPTH), .NSL(1)) u_meta_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_be   (w_meta_wr),
        .i_wr_addr (r_meta_wp),
        .i_wr_data (w_meta_wdata),
        .i_rd_addr (sm_addr_i),
        .o_rd_data (w_meta_q)
    );

    // Capture / trigger / freeze / playback state machine with its registered status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_CAPTURE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_meta_wp  <= '0;
            r_meta_cnt <= '0;
            r_wrapped  <= 1'b0;
            r_frozen   <= 1'b0;
            r_pb_done  <= 1'b0;
        end else begin
            if (w_cap_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_wr_ptr == AW'(MEM_DEPTH - 1)) begin
                    r_wrapped <= 1'b1;
                end
            end
            case (r_state)
                ST_CAPTURE: begin
                    r_pb_done <= 1'b0;
                    if (freeze_i) begin
                        r_meta_wp <= r_meta_wp + MW'(1);
                        if (r_meta_cnt != (MW+1)'(META_DEPTH)) begin
                            r_meta_cnt <= r_meta_cnt + (MW+1)'(1);
                        end
                        if (post_trig_i == '0) begin
                            r_state  <= ST_FROZEN;
                            r_frozen <= 1'b1;
                        end else begin
                            r_state <= ST_POST;
                            r_cnt   <= post_trig_i;
                        end
                    end
                end
                ST_POST: begin
                    if (spy_vld_i) begin
                        r_cnt <= r_cnt - AW'(1);
                        if (r_cnt == AW'(1)) begin
                            r_state  <= ST_FROZEN;
                            r_frozen <= 1'b1;
                        end
                    end
                end
                ST_FROZEN: begin
                    if (release_i) begin
                        r_state   <= ST_CAPTURE;
                        r_wr_ptr  <= '0;
                        r_wrapped <= 1'b0;
                        r_frozen  <= 1'b0;
                        r_pb_done <= 1'b0;
                    end else if (w_mode_pb && !r_pb_done) begin
                        r_state  <= ST_PLAY;
                        r_rd_ptr <= '0;
                    end else if (!w_mode_pb) begin
                        // A finished one-shot re-arms only once the mode goes back to spy
                        r_pb_done <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (release_i) begin
                        r_state   <= ST_CAPTURE;
                        r_wr_ptr  <= '0;
                        r_wrapped <= 1'b0;
                        r_frozen  <= 1'b0;
                    end else if (!w_mode_pb) begin
                        r_state <= ST_FROZEN;
                    end else if (w_at_last) begin
                        r_rd_ptr <= '0;
                        if (w_mode_once) begin
                            r_state   <= ST_FROZEN;
                            r_pb_done <= 1'b1;
                        end
                    end else begin
                        r_rd_ptr <= r_rd_ptr + AW'(1);
                    end
                end
                default: r_state <= ST_CAPTURE;
            endcase
        end
    end

    // Second read stage: slice mux / metadata / playback output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb_vld_d1   <= 1'b0;
            r_sb_slice_d1 <= '0;
            r_sm_vld_d1   <= 1'b0;
            r_pb_vld_d1   <= 1'b0;
            r_sb_rd_data  <= '0;
            r_sb_rd_vld   <= 1'b0;
            r_sm_rd_data  <= '0;
            r_sm_rd_vld   <= 1'b0;
            r_pb_data     <= '0;
            r_pb_vld      <= 1'b0;
        end else begin
            r_sb_vld_d1   <= sb_en_i && !sb_wr_en_i;
            r_sb_slice_d1 <= w_sb_slice;
            r_sm_vld_d1   <= sm_en_i;
            r_pb_vld_d1   <= w_pb_issue;
            r_sb_rd_vld   <= r_sb_vld_d1;
            r_sm_rd_vld   <= r_sm_vld_d1;
            r_pb_vld      <= r_pb_vld_d1;
            if (r_sb_vld_d1) begin
                r_sb_rd_data <= w_slice_q;
            end
            if (r_sm_vld_d1) begin
                r_sm_rd_data <= w_meta_q;
            end
            if (r_pb_vld_d1) begin
                r_pb_data <= w_dat_q;
            end
        end
    end

    assign sb_rd_data_o = r_sb_rd_data;
    assign sb_rd_vld_o  = r_sb_rd_vld;
    assign sm_rd_data_o = r_sm_rd_data;
    assign sm_rd_vld_o  = r_sm_rd_vld;
    assign pb_data_o    = r_pb_data;
    assign pb_vld_o     = r_pb_vld;
    assign frozen_o     = r_frozen;
    assign wrapped_o    = r_wrapped;
    assign wr_ptr_o     = r_wr_ptr;
    assign meta_cnt_o   = r_meta_cnt;

endmodule

// File: tb/tb_fm_spybuffer_pb.sv
// Self-checking bench for fm_spybuffer_pb against a behavioural memory/metadata model.
// Inputs change 1 ns after the rising edge, outputs are sampled there too.
// Random data words and gaps come from $urandom.
module tb_fm_spybuffer_pb;

    localparam int DW = 256, ADW = 32, DEPTH = 1024, MDEPTH = 32;
    localparam int AW = 10, MW = 5, NSL = 8, SW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DW-1:0]     spy_data_i = '0;
    logic              spy_vld_i = 1'b0, freeze_i = 1'b0, release_i = 1'b0;
    logic [AW-1:0]     post_trig_i = '0;
    logic [1:0]        pb_mode_i = '0;
    logic [AW:0]       pb_len_i = '0;
    logic [AW+SW-1:0]  sb_addr_i = '0;
    logic              sb_en_i = 1'b0, sb_wr_en_i = 1'b0;
    logic [ADW-1:0]    sb_wr_data_i = '0;
    logic [ADW-1:0]    sb_rd_data_o;
    logic              sb_rd_vld_o;
    logic [MW-1:0]     sm_addr_i = '0;
    logic              sm_en_i = 1'b0;
    logic [ADW-1:0]    sm_rd_data_o;
    logic              sm_rd_vld_o;
    logic [DW-1:0]     pb_data_o;
    logic              pb_vld_o, frozen_o, wrapped_o;
    logic [AW-1:0]     wr_ptr_o;
    logic [MW:0]       meta_cnt_o;

    fm_spybuffer_pb dut (
        .clk(clk), .rst(rst), .spy_data_i(spy_data_i), .spy_vld_i(spy_vld_i),
        .freeze_i(freeze_i), .release_i(release_i), .post_trig_i(post_trig_i),
        .pb_mode_i(pb_mode_i), .pb_len_i(pb_len_i), .sb_addr_i(sb_addr_i),
        .sb_en_i(sb_en_i), .sb_wr_en_i(sb_wr_en_i), .sb_wr_data_i(sb_wr_data_i),
        .sb_rd_data_o(sb_rd_data_o), .sb_rd_vld_o(sb_rd_vld_o),
        .sm_addr_i(sm_addr_i), .sm_en_i(sm_en_i), .sm_rd_data_o(sm_rd_data_o),
        .sm_rd_vld_o(sm_rd_vld_o), .pb_data_o(pb_data_o), .pb_vld_o(pb_vld_o),
        .frozen_o(frozen_o), .wrapped_o(wrapped_o), .wr_ptr_o(wr_ptr_o),
        .meta_cnt_o(meta_cnt_o)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [DW-1:0]  mdl_mem [DEPTH];
    logic [ADW-1:0] mdl_meta [MDEPTH];
    int             mdl_wp, mdl_meta_wp, mdl_meta_cnt;
    bit             mdl_wrapped;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] mk_word(input int idx);
        logic [DW-1:0] w;
        for (int s = 0; s < NSL; s++) w[s*ADW +: ADW] = $urandom;
        w[ADW-1:0] = ADW'(idx);
        return w;
    endfunction

    // One valid capture word, optionally followed by an idle cycle
    task automatic cap_word(input logic [DW-1:0] d);
        spy_data_i = d;
        spy_vld_i  = 1'b1;
        step();
        spy_vld_i  = 1'b0;
        mdl_mem[mdl_wp] = d;
        mdl_wp = (mdl_wp + 1) % DEPTH;
        if (mdl_wp == 0) mdl_wrapped = 1'b1;
        if ($urandom_range(0, 3) == 0) step();
    endtask

    task automatic trigger(input int post);
        post_trig_i = AW'(post);
        freeze_i    = 1'b1;
        step();
        freeze_i    = 1'b0;
        mdl_meta[mdl_meta_wp] = (ADW'(mdl_wrapped) << AW) | ADW'(mdl_wp);
        mdl_meta_wp = (mdl_meta_wp + 1) % MDEPTH;
        if (mdl_meta_cnt < MDEPTH) mdl_meta_cnt++;
    endtask

    task automatic axi_rd(input int w, input int s, output logic [ADW-1:0] d, output logic v);
        logic [AW-1:0] wa;
        logic [SW-1:0] sa;
        wa = AW'(w);
        sa = SW'(s);
        sb_addr_i  = {wa, sa};
        sb_en_i    = 1'b1;
        sb_wr_en_i = 1'b0;
        step();
        sb_en_i = 1'b0;
        step();
        d = sb_rd_data_o;
        v = sb_rd_vld_o;
    endtask

    task automatic axi_wr(input int w, input int s, input logic [ADW-1:0] d);
        logic [AW-1:0] wa;
        logic [SW-1:0] sa;
        wa = AW'(w);
        sa = SW'(s);
        sb_addr_i    = {wa, sa};
        sb_wr_data_i = d;
        sb_en_i      = 1'b1;
        sb_wr_en_i   = 1'b1;
        step();
        sb_en_i    = 1'b0;
        sb_wr_en_i = 1'b0;
    endtask

    task automatic meta_rd(input int a, output logic [ADW-1:0] d, output logic v);
        sm_addr_i = MW'(a);
        sm_en_i   = 1'b1;
        step();
        sm_en_i = 1'b0;
        step();
        d = sm_rd_data_o;
        v = sm_rd_vld_o;
    endtask

    // Watch a playback window: first valid cycle, last valid cycle, words seen
    logic [DW-1:0] got_q[$];
    int            pb_first, pb_last;

    task automatic pb_watch(input int cycles);
        got_q.delete();
        pb_first = -1;
        pb_last  = -1;
        for (int c = 1; c <= cycles; c++) begin
            step();
            if (pb_vld_o) begin
                if (pb_first < 0) pb_first = c;
                pb_last = c;
                got_q.push_back(pb_data_o);
            end
        end
    endtask

    task automatic play_once(input int len);
        pb_len_i  = (AW+1)'(len);
        pb_mode_i = 2'd1;
        pb_watch(len + 12);
        check_eq($sformatf("once%0d_first_vld", len), pb_first, 3);
        check_eq($sformatf("once%0d_count", len), got_q.size(), len);
        check_eq($sformatf("once%0d_contig", len), pb_last - pb_first + 1, len);
        for (int k = 0; k < len && k < got_q.size(); k++)
            check_eq($sformatf("once%0d_word%0d", len, k), got_q[k], mdl_mem[k]);
        check_eq($sformatf("once%0d_frozen", len), frozen_o, 1'b1);
        pb_mode_i = 2'd0;
        step();
    endtask

    logic [ADW-1:0] rd;
    logic           rv;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mdl_wp = 0; mdl_meta_wp = 0; mdl_meta_cnt = 0; mdl_wrapped = 1'b0;
        step(); step(); step();
        rst = 1'b0;
        step();

        // Reset state
        check_eq("rst_frozen", frozen_o, 1'b0);
        check_eq("rst_wrapped", wrapped_o, 1'b0);
        check_eq("rst_wr_ptr", wr_ptr_o, 0);
        check_eq("rst_meta_cnt", meta_cnt_o, 0);
        check_eq("rst_pb_vld", pb_vld_o, 1'b0);
        check_eq("rst_sb_rd_vld", sb_rd_vld_o, 1'b0);

        // Capture 1030 words through a wrap
        for (int i = 0; i < 1030; i++) cap_word(mk_word(i));
        check_eq("wrap_flag", wrapped_o, 1'b1);
        check_eq("wrap_wr_ptr", wr_ptr_o, 6);
        axi_rd(5, 0, rd, rv);
        check_eq("wrap_rd_vld", rv, 1'b1);
        check_eq("wrap_word5_s0", rd, 1029);
        for (int k = 0; k < 6; k++) begin
            int w, s;
            w = $urandom_range(0, DEPTH - 1);
            s = $urandom_range(0, NSL - 1);
            axi_rd(w, s, rd, rv);
            check_eq($sformatf("rand_rd_w%0d_s%0d", w, s), rd, mdl_mem[w][s*ADW +: ADW]);
        end

        // Trigger with zero post-count freezes at once
        trigger(0);
        check_eq("post0_frozen", frozen_o, 1'b1);
        check_eq("post0_meta_cnt", meta_cnt_o, mdl_meta_cnt);
        meta_rd(0, rd, rv);
        check_eq("post0_meta_vld", rv, 1'b1);
        check_eq("post0_meta0", rd, mdl_meta[0]);

        // Freeze + release together while frozen: release wins, no new entry
        freeze_i = 1'b1; release_i = 1'b1;
        step();
        freeze_i = 1'b0; release_i = 1'b0;
        mdl_wp = 0; mdl_wrapped = 1'b0;
        check_eq("collide_frozen", frozen_o, 1'b0);
        check_eq("collide_wr_ptr", wr_ptr_o, 0);
        check_eq("collide_wrapped", wrapped_o, 1'b0);
        check_eq("collide_meta_cnt", meta_cnt_o, mdl_meta_cnt);

        // AXI data writes are ignored during capture
        axi_wr(900, 2, 32'h1234_5678);
        axi_rd(900, 2, rd, rv);
        check_eq("cap_axi_wr_ignored", rd, mdl_mem[900][2*ADW +: ADW]);

        // Post-trigger count of 4 from wr_ptr 100
        for (int i = 0; i < 100; i++) cap_word(mk_word(2000 + i));
        check_eq("pre_trig_wr_ptr", wr_ptr_o, 100);
        trigger(4);
        check_eq("post_state_not_frozen", frozen_o, 1'b0);
        freeze_i = 1'b1;
        step();
        freeze_i = 1'b0;
        check_eq("post_freeze_ignored", meta_cnt_o, mdl_meta_cnt);
        for (int i = 0; i < 4; i++) begin
            cap_word(mk_word(3000 + i));
            check_eq($sformatf("post_frozen_after_%0d", i + 1), frozen_o, i == 3);
        end
        check_eq("post_wr_ptr", wr_ptr_o, 104);
        check_eq("post_meta_cnt", meta_cnt_o, 2);
        meta_rd(1, rd, rv);
        check_eq("post_meta1", rd, 100);

        // Single-slice AXI write in FROZEN
        axi_wr(3, 7, 32'hDEAD_BEEF);
        mdl_mem[3][7*ADW +: ADW] = 32'hDEAD_BEEF;
        for (int s = 0; s < NSL; s++) begin
            axi_rd(3, s, rd, rv);
            check_eq($sformatf("slice_wr_w3_s%0d", s), rd, mdl_mem[3][s*ADW +: ADW]);
        end

        // One-shot playback, fixed and random length
        play_once(8);
        play_once($urandom_range(1, 12));

        // Looping playback of 3 words, then release aborts it
        pb_len_i  = (AW+1)'(3);
        pb_mode_i = 2'd2;
        pb_watch(12);
        check_eq("loop_first_vld", pb_first, 3);
        check_eq("loop_count", got_q.size(), 10);
        for (int k = 0; k < got_q.size(); k++)
            check_eq($sformatf("loop_word%0d", k), got_q[k], mdl_mem[k % 3]);
        release_i = 1'b1;
        step();
        release_i = 1'b0;
        pb_mode_i = 2'd0;
        step();
        mdl_wp = 0; mdl_wrapped = 1'b0;
        check_eq("abort_pb_vld", pb_vld_o, 1'b0);
        check_eq("abort_frozen", frozen_o, 1'b0);
        check_eq("abort_wr_ptr", wr_ptr_o, 0);

        // Asynchronous reset in the middle of POST
        for (int i = 0; i < 3; i++) cap_word(mk_word(4000 + i));
        trigger(5);
        cap_word(mk_word(4100));
        cap_word(mk_word(4101));
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_wr_ptr", wr_ptr_o, 0);
        check_eq("arst_meta_cnt", meta_cnt_o, 0);
        check_eq("arst_flags", {frozen_o, wrapped_o, pb_vld_o, sb_rd_vld_o, sm_rd_vld_o}, 0);
        check_eq("arst_data", {sb_rd_data_o, sm_rd_data_o, pb_data_o[ADW-1:0]}, 0);
        step();
        rst = 1'b0;
        mdl_wp = 0; mdl_wrapped = 1'b0; mdl_meta_wp = 0; mdl_meta_cnt = 0;
        step();
        cap_word(mk_word(5000));
        check_eq("after_rst_wr_ptr", wr_ptr_o, 1);
        trigger(0);
        check_eq("after_rst_frozen", frozen_o, 1'b1);
        check_eq("after_rst_meta_cnt", meta_cnt_o, 1);
        meta_rd(0, rd, rv);
        check_eq("after_rst_meta0", rd, mdl_meta[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fm_spybuffer_pb.md
# fm_spybuffer_pb

Parametrised single-channel spy buffer with playback for the FM (fast-monitoring) subsystem. Captures a stream of up-to-`DATA_WIDTH`-bit words into a circular memory, freezes on a trigger after a programmable post-trigger count, records trigger metadata, and exposes both memories to AXI as `AXI_DW`-bit slices. It also replays the memory contents onto the datapath in one-shot or loop mode. One instance per spy point; the FM top instantiates `total_sb` of them.

## Interface
- `DATA_WIDTH`, 256: captured word width; must be a multiple of `AXI_DW`.
- `AXI_DW`, 32: AXI data width.
- `MEM_DEPTH`, 1024: data words, power of 2; `AW = $clog2(MEM_DEPTH)`.
- `META_DEPTH`, 32: metadata entries, power of 2; `MW = $clog2(META_DEPTH)`.
- `PB_MODE_WIDTH`, 2: playback-mode field width.
- Derived: `NSL = DATA_WIDTH/AXI_DW`, `SW = $clog2(NSL)` (minimum 1).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock; all logic is in this domain.
- `rst` in 1: asynchronous, active-high reset.
- `spy_data_i` in DATA_WIDTH: monitored data.
- `spy_vld_i` in 1: monitored data valid.
- `freeze_i` in 1: trigger pulse.
- `release_i` in 1: pulse; leaves FROZEN or playback and restarts capture.
- `post_trig_i` in AW: words captured after the trigger.
- `pb_mode_i` in PB_MODE_WIDTH: 0 spy, 1 playback-once, 2 playback-loop, 3 treated as 0.
- `pb_len_i` in AW+1: number of playback words, 1..MEM_DEPTH; 0 is treated as MEM_DEPTH.
- `sb_addr_i` in AW+SW: AXI data address as {word, slice}.
- `sb_en_i`, `sb_wr_en_i` in 1: AXI data access strobe and write qualifier.
- `sb_wr_data_i` in AXI_DW: AXI write data.
- `sb_rd_data_o` out AXI_DW, `sb_rd_vld_o` out 1: AXI read data and valid.
- `sm_addr_i` in MW, `sm_en_i` in 1: metadata read address and strobe.
- `sm_rd_data_o` out AXI_DW, `sm_rd_vld_o` out 1: metadata read data and valid.
- `pb_data_o` out DATA_WIDTH, `pb_vld_o` out 1: playback stream and valid.
- `frozen_o`, `wrapped_o` out 1: status flags.
- `wr_ptr_o` out AW: current write pointer.
- `meta_cnt_o` out MW+1: number of valid metadata entries (saturating).

## Operation
- States: CAPTURE, POST, FROZEN, PLAY.
- Reset puts the block in CAPTURE with all pointers and counters at 0 and all outputs at 0.
- CAPTURE (`pb_mode_i` 0 or 3):
  - Each `spy_vld_i` writes the word at `wr_ptr` and increments `wr_ptr` modulo MEM_DEPTH.
  - Wrap from MEM_DEPTH-1 to 0 sets `wrapped_o`, which is sticky until release or reset.
- Trigger handling in CAPTURE:
  - `freeze_i` writes a metadata entry at `meta_wp`, then `meta_wp++` modulo META_DEPTH and `meta_cnt` saturates at META_DEPTH.
  - Entry layout: {16'h0 pad, wrapped, `wr_ptr` at trigger}, zero-extended to AXI_DW.
  - If `post_trig_i`==0 the next state is FROZEN; otherwise the next state is POST with `cnt=post_trig_i`.
- POST: each valid write decrements `cnt`; the write that brings `cnt` to 0 is stored, then the state moves to FROZEN. `freeze_i` is ignored in POST.
- FROZEN:
  - No capture; `frozen_o`=1.
  - AXI writes are allowed: slice `s` of word `w` is updated, other slices are unchanged (per-slice write enable).
  - `release_i` moves to CAPTURE and clears `wr_ptr`, `wrapped_o`, `frozen_o`; metadata is kept.
- Entering and leaving PLAY:
  - From FROZEN, `pb_mode_i` 1 or 2 moves to PLAY with `rd_ptr=0`.
  - Playback-once emits `pb_len` words then returns to FROZEN.
  - Playback-loop wraps `rd_ptr` to 0 after `pb_len`-1 and continues.
  - In PLAY, `pb_mode_i` becoming 0 or 3, or `release_i`, aborts playback and returns to FROZEN or CAPTURE respectively on the next cycle.
- AXI write rules: AXI data writes are ignored in CAPTURE and POST. A metadata write port does not exist.
- AXI reads are allowed in every state; slice `sb_addr_i[SW-1:0]` is taken from word `sb_addr_i[AW+SW-1:SW]`.

## Timing
- Capture write takes effect at the `clk` edge where `spy_vld_i`=1; `wr_ptr_o` updates on the same edge.
- AXI read (data or metadata) latency is 2 cycles: RAM register, then slice mux register. `*_rd_vld_o` is a 2-cycle delayed copy of `*_en_i & ~sb_wr_en_i` (data) or `sm_en_i` (metadata).
- Playback: the first `pb_vld_o` appears 2 cycles after entering PLAY; thereafter one word per cycle with no gaps. `pb_vld_o` drops 2 cycles after the last read issues or after an abort.
- Read-during-write to the same address returns old data.
- Simultaneous `freeze_i` and `release_i` in FROZEN: release wins. In CAPTURE: freeze wins.
- `rst` asserted mid-operation immediately clears state; memory contents are undefined but are not cleared.

## Structure
- `fm_sb_pkg` gains:
  - mode constants `PB_SPY`, `PB_ONCE`, `PB_LOOP`;
  - a state enum `sb_state_t`;
  - a metadata struct `sb_meta_t`;
  - a `fm_sb_cfg_t` parameter bundle.
- The existing `axi_*` arrays remain the top-level aggregation.
- Sub-module `fm_sb_sdp_ram`: a simple dual-port RAM with per-slice write enable and registered read. It is instantiated once for data (DATA_WIDTH × MEM_DEPTH) and once for metadata (AXI_DW × META_DEPTH).

## Test plan
- Capture and wrap: defaults, 1030 valid words with data=index → `wrapped_o`=1, `wr_ptr_o`=6, AXI read word 5 slice 0 = 1029.
- Post-trigger: `post_trig_i`=4 with `freeze_i` at `wr_ptr`=100 → `frozen_o` after 4 more words, `wr_ptr_o`=104, meta[0]=100, `meta_cnt_o`=1.
- Slice write: FROZEN, AXI write word 3 slice 7 = 32'hDEADBEEF → other slices of word 3 are unchanged; read returns DEADBEEF after 2 cycles.
- Playback-once: `pb_len_i`=8 → exactly 8 consecutive `pb_vld_o` carrying words 0..7, then the block is back in FROZEN.
- Playback-loop abort: loop with `pb_len_i`=3 → sequence 0,1,2,0,1,… ; `release_i` → `pb_vld_o` low within 2 cycles, CAPTURE, `wr_ptr_o`=0.
- Reset and collisions: assert `rst` in POST → all outputs 0 and state CAPTURE; simultaneous `freeze_i` and `release_i` in FROZEN → CAPTURE with no new metadata entry.
